product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 138 +++++++++++++
 tb/tb_product_accumulator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a batch of 1..16 signed products and presents the total on a ready/valid output.
// Define PRODUCT_ACC_SAT_EN to clamp on overflow (and flag out_sat) instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [15:0]      in_product,
  input  logic [3:0]              batch_len,
  input  logic                    clear,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_sat,
  output logic                    overrun,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [4:0]              len_q, len_d;
  logic                    ovr_q, ovr_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum;
  logic                    sat_hit;
  logic [4:0]              eff_len;
  logic [4:0]              cnt_inc;
  logic                    start;

  assign prod_ext = {{(ACC_W-16){in_product[15]}}, in_product};
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign eff_len  = (batch_len == 4'd0) ? 5'd16 : {1'b0, batch_len};
  assign cnt_inc  = cnt_q + 5'd1;

`ifdef PRODUCT_ACC_SAT_EN
  // Top two bits of the one-bit-wider sum disagree exactly on signed overflow.
  always_comb begin
    sat_hit = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum     = sum_wide[ACC_W-1:0];
    if (sat_hit)
      sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign sat_hit = 1'b0;
  assign sum     = sum_wide[ACC_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    out_sum_d = out_sum_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovr_d     = ovr_q;
    sat_d     = sat_q;
    start     = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      out_sum_d = '0;
      cnt_d     = '0;
      ovr_d     = 1'b0;
      sat_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE:  start = in_valid;
        ACCUM: if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          sat_d = sat_q | sat_hit;
          if (cnt_inc == len_q) begin
            state_d   = HOLD;
            out_sum_d = sum;
          end
        end
        HOLD: if (out_ready) begin
          state_d = IDLE;
          start   = in_valid;
        end else if (in_valid) begin
          ovr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    // A product arriving alongside a HOLD transfer opens the next batch directly.
    if (start) begin
      acc_d = prod_ext;
      cnt_d = 5'd1;
      len_d = eff_len;
      sat_d = 1'b0;
      if (eff_len == 5'd1) begin
        state_d   = HOLD;
        out_sum_d = prod_ext;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      out_sum_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovr_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      out_sum_q <= out_sum_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovr_q     <= ovr_d;
      sat_q     <= sat_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == ACCUM);
  assign out_sum   = out_sum_q;
  assign overrun   = ovr_q;
`ifdef PRODUCT_ACC_SAT_EN
  assign out_sat   = sat_q;
`else
  assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator at ACC_W=18; inputs change and outputs
// are checked 1ns after each rising clock edge.
module tb_product_accumulator;
  localparam int ACC_W = 18;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic signed [15:0]      in_product;
  logic [3:0]              batch_len;
  logic                    clear;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_sat;
  logic                    overrun;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  product_accumulator #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_product(in_product),
    .batch_len(batch_len), .clear(clear), .out_ready(out_ready),
    .out_valid(out_valid), .out_sum(out_sum), .out_sat(out_sat),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] p, input logic [3:0] len);
    in_valid   = 1'b1;
    in_product = p;
    batch_len  = len;
    tick();
    in_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; batch_len = '0;
    clear = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_busy",      busy,      0);
    chk("rst_overrun",   overrun,   0);
    chk("rst_out_sat",   out_sat,   0);
    rst_n = 1'b1;
    tick();

    // len=4 batch with gaps between products
    out_ready = 1'b1;
    send(100, 4);
    chk("b4_busy_after_first", busy, 1);
    tick();
    send(-50, 4);
    send(7, 4);
    tick(); tick(); tick();
    chk("b4_no_early_valid", out_valid, 0);
    send(3, 4);
    chk("b4_out_valid", out_valid, 1);
    chk("b4_out_sum",   out_sum,   60);
    chk("b4_busy_hold", busy,      0);
    tick();
    chk("b4_valid_one_cycle", out_valid, 0);
    chk("b4_sum_held",        out_sum,   60);

    // len=1 result held under backpressure; extra product dropped
    out_ready = 1'b0;
    send(-16256, 1);
    chk("hold_valid_0", out_valid, 1);
    chk("hold_sum_0",   out_sum,   -16256);
    tick();
    send(77, 1);
    chk("hold_overrun", overrun, 1);
    chk("hold_sum_kept", out_sum, -16256);
    tick(); tick();
    chk("hold_valid_5", out_valid, 1);
    chk("hold_sum_5",   out_sum,   -16256);
    out_ready = 1'b1;
    tick();
    chk("hold_released", out_valid, 0);
    chk("overrun_sticky", overrun, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_overrun", overrun, 0);
    chk("clr_out_sum", out_sum, 0);

    // transfer and new product in the same cycle
    out_ready = 1'b0;
    send(60, 1);
    chk("xfer_pre_sum", out_sum, 60);
    out_ready = 1'b1;
    send(5, 2);
    chk("xfer_busy",    busy,      1);
    chk("xfer_valid",   out_valid, 0);
    chk("xfer_overrun", overrun,   0);
    send(5, 9);
    chk("xfer_valid2", out_valid, 1);
    chk("xfer_sum2",   out_sum,   10);
    tick();

    // clear mid-batch, then a full batch; batch_len changes mid-batch are ignored
    send(20, 3);
    send(30, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_mid_busy", busy,    0);
    chk("clr_mid_sum",  out_sum, 0);
    send(1, 3);
    send(1, 1);
    chk("len_latched", out_valid, 0);
    send(1, 7);
    chk("clr_batch_valid", out_valid, 1);
    chk("clr_batch_sum",   out_sum,   3);
    tick();

    // async reset mid-batch
    send(20, 3);
    send(30, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sum",  out_sum, 0);
    rst_n = 1'b1;
    tick();
    chk("arst_no_valid", out_valid, 0);
    send(1, 3);
    send(1, 3);
    send(1, 3);
    chk("arst_batch_valid", out_valid, 1);
    chk("arst_batch_sum",   out_sum,   3);
    tick();

    // batch_len=0 means 16; 16*16384 = 2^18 overflows ACC_W=18
    for (int i = 0; i < 15; i++) send(16384, 0);
    chk("len16_busy_15", busy, 1);
    send(16384, 0);
    chk("len16_valid", out_valid, 1);
`ifdef PRODUCT_ACC_SAT_EN
    chk("len16_sum_sat", out_sum, 131071);
    chk("len16_sat",     out_sat, 1);
    tick();
    send(4, 1);
    chk("sat_cleared", out_sat, 0);
`else
    // wraps through -131072 after the 8th product and back to 0 after the 16th
    chk("len16_sum_wrap", out_sum, 0);
    chk("len16_nosat",    out_sat, 0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
